// File: rtl/cache_repl_policy.sv
// Per-set replacement-state engine: true LRU, tree PLRU or FIFO victim selection,
// invalid-way preference, and a one-set-per-cycle flush walk.
module cache_repl_policy #(
  parameter int WAYS       = 4,
  parameter int TOTAL_SIZE = 16,
  parameter int POLICY     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                re,
  input  logic                                we,
  input  logic                                fill,
  input  logic [$clog2(WAYS)-1:0]             way,
  input  logic [$clog2(TOTAL_SIZE/WAYS)-1:0]  index,
  input  logic [WAYS-1:0]                     valid_mask,
  input  logic                                flush,
  output logic [$clog2(WAYS)-1:0]             replace_way,
  output logic                                busy
);

  localparam int SETS = TOTAL_SIZE / WAYS;
  localparam int WL   = $clog2(WAYS);
  localparam int SL   = $clog2(SETS);

  if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $error("cache_repl_policy: WAYS must be a power of two >= 2");
  end
  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("cache_repl_policy: TOTAL_SIZE/WAYS must be a power of two >= 2");
  end

  typedef enum logic [0:0] {IDLE, WALK} state_t;

  state_t          state_q, state_d;
  logic [SL-1:0]   cnt_q, cnt_d;
  logic            access;
  logic            has_inv;
  logic [WL-1:0]   inv_way;
  logic [WL-1:0]   pol_victim;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = WALK;
          cnt_d   = '0;
        end
      end
      WALK: begin
        cnt_d = cnt_q + SL'(1);
        if (cnt_q == SL'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == WALK);
  // A flush in the same cycle as an access wins; the access is dropped.
  assign access = (re | we | fill) & ~busy & ~flush;

  always_comb begin
    has_inv = 1'b0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_mask[i]) begin
        has_inv = 1'b1;
        inv_way = WL'(i);
      end
    end
  end

  assign replace_way = busy ? '0 : (has_inv ? inv_way : pol_victim);

  if (POLICY == 0) begin : g_lru
    // slots[s][0] is the LRU way, slots[s][WAYS-1] the MRU way.
    logic [WL-1:0] slots [SETS][WAYS];
    logic [WL-1:0] nxt [WAYS];

    always_comb begin
      int k;
      k = 0;
      for (int i = 0; i < WAYS; i++) begin
        if (slots[index][i] == way) k = i;
      end
      for (int i = 0; i < WAYS - 1; i++) begin
        nxt[i] = (i < k) ? slots[index][i] : slots[index][i+1];
      end
      nxt[WAYS-1] = way;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++)
          for (int i = 0; i < WAYS; i++) slots[s][i] <= WL'(i);
      end else if (busy) begin
        for (int i = 0; i < WAYS; i++) slots[cnt_q][i] <= WL'(i);
      end else if (access) begin
        for (int i = 0; i < WAYS; i++) slots[index][i] <= nxt[i];
      end
    end

    assign pol_victim = slots[index][0];
  end else if (POLICY == 1) begin : g_plru
    logic [WAYS-2:0] tree [SETS];
    logic [WAYS-2:0] tnxt;

    // Level l, position p lies on way's path when way's top l bits equal p.
    always_comb begin
      tnxt = tree[index];
      for (int l = 0; l < WL; l++) begin
        for (int p = 0; p < (1 << l); p++) begin
          if ((int'(way) >> (WL - l)) == p) tnxt[(1 << l) - 1 + p] = ~way[WL-1-l];
        end
      end
    end

    always_comb begin
      int v;
      v = 0;
      for (int l = 0; l < WL; l++) begin
        v = 2 * v + (tree[index][(1 << l) - 1 + v] ? 1 : 0);
      end
      pol_victim = WL'(v);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) tree[s] <= '0;
      end else if (busy) begin
        tree[cnt_q] <= '0;
      end else if (access) begin
        tree[index] <= tnxt;
      end
    end
  end else if (POLICY == 2) begin : g_fifo
    logic [WL-1:0] ptr [SETS];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) ptr[s] <= '0;
      end else if (busy) begin
        ptr[cnt_q] <= '0;
      end else if (access && fill) begin
        ptr[index] <= ptr[index] + WL'(1);
      end
    end

    assign pol_victim = ptr[index];
  end else begin : g_bad_policy
    $error("cache_repl_policy: POLICY must be 0, 1 or 2");
    assign pol_victim = '0;
  end

endmodule

// File: tb/tb_cache_repl_policy.sv
// Drives LRU, PLRU and FIFO instances with shared directed stimulus and checks them
// against a queue/array model every cycle plus hand-computed literal expectations.
module tb_cache_repl_policy;

  localparam int WAYS = 4;
  localparam int TOTAL = 16;
  localparam int SETS = 4;

  logic            clk = 1'b0;
  logic            rst, re, we, fill, flush;
  logic [1:0]      way, index;
  logic [3:0]      mask;
  logic [2:0][1:0] rw;
  logic [2:0]      busyv;

  int total = 0;
  int bad   = 0;
  bit modelOn = 1'b0;

  int lruQ [SETS][$];
  bit plru [SETS][3];
  int fifoPtr [SETS];
  int busyLeft = 0;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 3; p++) begin : g_dut
    cache_repl_policy #(.WAYS(WAYS), .TOTAL_SIZE(TOTAL), .POLICY(p)) u_dut (
      .clk(clk), .rst(rst), .re(re), .we(we), .fill(fill), .way(way), .index(index),
      .valid_mask(mask), .flush(flush), .replace_way(rw[p]), .busy(busyv[p])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic initSet(input int s);
    lruQ[s] = {0, 1, 2, 3};
    for (int n = 0; n < 3; n++) plru[s][n] = 1'b0;
    fifoPtr[s] = 0;
  endtask

  task automatic modelAccess(input int s, input int w, input bit f);
    int n;
    for (int i = 0; i < lruQ[s].size(); i++) begin
      if (lruQ[s][i] == w) begin
        lruQ[s].delete(i);
        break;
      end
    end
    lruQ[s].push_back(w);
    n = 0;
    for (int l = 0; l < 2; l++) begin
      int d;
      d = (w >> (1 - l)) & 1;
      plru[s][n] = (d == 0);
      n = 2 * n + 1 + d;
    end
    if (f) fifoPtr[s] = (fifoPtr[s] + 1) % WAYS;
  endtask

  function automatic int modelVictim(input int p, input int s, input logic [3:0] m);
    int n;
    if (busyLeft > 0) return 0;
    for (int i = 0; i < WAYS; i++) if (m[i] !== 1'b1) return i;
    if (p == 0) return lruQ[s][0];
    if (p == 1) begin
      n = 0;
      while (n < 3) n = 2 * n + 1 + (plru[s][n] ? 1 : 0);
      return n - 3;
    end
    return fifoPtr[s];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) initSet(s);
      busyLeft = 0;
      modelOn  = 1'b1;
    end else if (busyLeft > 0) begin
      initSet(SETS - busyLeft);
      busyLeft--;
    end else if (flush) begin
      busyLeft = SETS;
    end else if (re || we || fill) begin
      modelAccess(int'(index), int'(way), fill);
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      for (int p = 0; p < 3; p++) begin
        checkOutput($sformatf("cycle_rw_p%0d", p), rw[p], modelVictim(p, int'(index), mask));
        checkOutput($sformatf("cycle_busy_p%0d", p), busyv[p], (busyLeft > 0) ? 1 : 0);
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit w, input bit f, input int wy,
                               input int idx, input bit fl);
    re = r; we = w; fill = f; flush = fl;
    way = 2'(wy); index = 2'(idx);
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0; fill = 1'b0; flush = 1'b0;
  endtask

  task automatic setView(input int idx, input logic [3:0] m);
    index = 2'(idx); mask = m;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0; re = 1'b0; we = 1'b0; fill = 1'b0; flush = 1'b0;
    way = 2'd0; index = 2'd0; mask = 4'b1111;
    doReset();
    for (int p = 0; p < 3; p++) begin
      checkOutput("reset_rw", rw[p], 0);
      checkOutput("reset_busy", busyv[p], 0);
    end

    // LRU ordering on set 1
    for (int w = 0; w < 3; w++) applyStimulus(1, 0, 0, w, 1, 0);
    checkOutput("lru_after_012", rw[0], 3);
    applyStimulus(0, 1, 0, 3, 1, 0);
    checkOutput("lru_after_3", rw[0], 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("lru_after_00", rw[0], 1);
    setView(2, 4'b1111);
    checkOutput("lru_other_set", rw[0], 0);

    // PLRU tree walk on set 0
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("plru_touch0", rw[1], 2);
    applyStimulus(1, 0, 0, 2, 0, 0);
    checkOutput("plru_touch2", rw[1], 1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("plru_touch1", rw[1], 3);
    applyStimulus(1, 1, 0, 3, 0, 0);
    checkOutput("plru_rewe3", rw[1], 0);
    checkOutput("lru_rewe3", rw[0], 0);

    // FIFO on set 3
    for (int w = 0; w < 3; w++) applyStimulus(0, 0, 1, w, 3, 0);
    checkOutput("fifo_3fills", rw[2], 3);
    applyStimulus(1, 0, 0, 0, 3, 0);
    applyStimulus(0, 1, 0, 1, 3, 0);
    checkOutput("fifo_rewe_nofill", rw[2], 3);
    applyStimulus(0, 0, 1, 3, 3, 0);
    checkOutput("fifo_wrap", rw[2], 0);
    checkOutput("lru_set3_mixed", rw[0], 2);

    // Invalid-way preference on set 3
    setView(3, 4'b1011);
    for (int p = 0; p < 3; p++) checkOutput("inv_1011", rw[p], 2);
    @(posedge clk); #1;
    setView(3, 4'b0000);
    for (int p = 0; p < 3; p++) checkOutput("inv_0000", rw[p], 0);
    @(posedge clk); #1;
    setView(3, 4'b1111);
    checkOutput("inv_restore_lru", rw[0], 2);
    checkOutput("inv_restore_plru", rw[1], 0);
    checkOutput("inv_restore_fifo", rw[2], 0);

    // Flush walk after scrambling every set
    for (int s = 0; s < SETS; s++) begin
      applyStimulus(0, 0, 1, 3 - s, s, 0);
      applyStimulus(1, 0, 0, s, s, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    setView(3, 4'b0111);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (busyv[0]) n++;
      if (c == 0) begin
        checkOutput("flush_busy_start", busyv[0], 1);
        checkOutput("flush_rw_forced", rw[0], 0);
      end
      if (c == 1) begin
        re = 1'b1; fill = 1'b1; way = 2'd2;
      end
      @(posedge clk); #1;
      re = 1'b0; fill = 1'b0;
    end
    checkOutput("flush_busy_cycles", n, 4);
    for (int s = 0; s < SETS; s++) begin
      setView(s, 4'b1111);
      for (int p = 0; p < 3; p++) checkOutput("flush_set_init", rw[p], 0);
    end
    for (int w = 0; w < 3; w++) begin
      applyStimulus(1, 0, 0, w, 0, 0);
      checkOutput("flush_lru_order", rw[0], w + 1);
    end

    // Reset on the second busy cycle aborts the walk
    applyStimulus(0, 0, 1, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("abort_busy1", busyv[0], 1);
    @(posedge clk); #1;
    checkOutput("abort_busy2", busyv[0], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int p = 0; p < 3; p++) checkOutput("abort_busy_off", busyv[p], 0);
    setView(3, 4'b1111);
    for (int p = 0; p < 3; p++) checkOutput("abort_set3_init", rw[p], 0);

    // Flush and access in the same idle cycle: access dropped
    applyStimulus(1, 0, 1, 0, 2, 1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("drop_busy_done", busyv[0], 0);
    for (int p = 0; p < 3; p++) checkOutput("drop_access", rw[p], 0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
